// File: rtl/imem_program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package : imem_program_loader_pkg
// Brief   : Frame field widths, magic byte and state codes for the loader.
// Rev     : 1.0 - initial release
// ============================================================================
package imem_program_loader_pkg;

    localparam int c_BYTE_W  = 8;
    localparam int c_WORD_W  = 32;
    localparam int c_CNT_W   = 16;
    localparam int c_STATE_W = 3;

    localparam logic [c_BYTE_W-1:0] c_MAGIC_DEFAULT = 8'hA5;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CNT_H = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_CNT_L = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DATA  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_CHECK = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd5;
    localparam logic [c_STATE_W-1:0] c_ST_ERROR = 3'd6;

endpackage
`default_nettype wire

// File: rtl/imem_program_loader_word_assembler.sv
`default_nettype none
// ============================================================================
// Module : imem_program_loader_word_assembler
// Brief  : Packs four little-endian bytes into a word and pulses word_ready.
// Rev    : 1.0 - initial release
// ============================================================================
module imem_program_loader_word_assembler
    import imem_program_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_shift_en,
    input  logic [c_BYTE_W-1:0] i_byte,
    output logic [1:0]          o_byte_idx,
    output logic                o_word_ready,
    output logic [c_WORD_W-1:0] o_word
);

    logic [1:0]          r_idx;
    logic [c_WORD_W-1:0] r_shift;
    logic [c_WORD_W-1:0] r_word;
    logic                r_ready;
    logic [c_WORD_W-1:0] w_shift_nxt;

    // New bytes enter at the top so the first byte ends up in [7:0].
    assign w_shift_nxt = {i_byte, r_shift[c_WORD_W-1:c_BYTE_W]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx   <= 2'd0;
            r_shift <= '0;
            r_word  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (i_clear) begin
                r_idx   <= 2'd0;
                r_shift <= '0;
            end else if (i_shift_en) begin
                r_shift <= w_shift_nxt;
                r_idx   <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_word  <= w_shift_nxt;
                    r_ready <= 1'b1;
                end
            end
        end
    end

    assign o_byte_idx   = r_idx;
    assign o_word_ready = r_ready;
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_program_loader
// Brief  : Framed byte-stream loader for the instruction memory; holds the
//          CPU in reset until a frame loads with a matching checksum.
// Rev    : 1.0 - initial release
// ============================================================================
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter logic [31:0]         BASE_ADDR = 32'd0,
    parameter logic [31:0]         ADDR_STEP = 32'd1,
    parameter int                  MAX_WORDS = 256,
    parameter logic [c_BYTE_W-1:0] MAGIC     = c_MAGIC_DEFAULT
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [c_BYTE_W-1:0] byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [c_WORD_W-1:0] imem_wdata,
    output logic                cpu_reset,
    output logic                load_done,
    output logic                load_error
);

    localparam logic [31:0] c_MAX_WORDS = 32'(MAX_WORDS);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 r_byte_ready;
    logic [31:0]          r_addr;
    logic [c_BYTE_W-1:0]  r_chk;
    logic [c_BYTE_W-1:0]  r_cnt_hi;
    logic [c_CNT_W-1:0]   r_remain;
    logic                 r_cpu_reset;
    logic                 r_done;
    logic                 r_error;

    logic                 w_xfer;
    logic                 w_start;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_too_big;
    logic                 w_shift_en;
    logic [1:0]           w_byte_idx;
    logic                 w_word_ready;
    logic [c_WORD_W-1:0]  w_word;

    assign w_xfer     = byte_valid & r_byte_ready;
    assign w_count    = {r_cnt_hi, byte_in};
    assign w_too_big  = ({16'd0, w_count} > c_MAX_WORDS);
    assign w_shift_en = w_xfer && (r_state == c_ST_DATA);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERROR: begin
                if (w_xfer && (byte_in == MAGIC)) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ST_CNT_H;
                end
            end
            c_ST_CNT_H: if (w_xfer) w_state_nxt = c_ST_CNT_L;
            c_ST_CNT_L: begin
                if (w_xfer) begin
                    if (w_too_big)                 w_state_nxt = c_ST_ERROR;
                    else if (w_count == 16'd0)     w_state_nxt = c_ST_CHECK;
                    else                           w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_xfer && (w_byte_idx == 2'd3) && (r_remain == 16'd1))
                    w_state_nxt = c_ST_CHECK;
            end
            c_ST_CHECK: begin
                if (w_xfer) w_state_nxt = (byte_in == r_chk) ? c_ST_DONE : c_ST_ERROR;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte_ready <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_chk        <= '0;
            r_cnt_hi     <= '0;
            r_remain     <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_byte_ready <= 1'b1;
            // The address steps once the strobe has been seen; a restart overrides it.
            if (w_word_ready) r_addr <= r_addr + ADDR_STEP;
            if (w_start) begin
                r_cpu_reset <= 1'b1;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
                r_addr      <= BASE_ADDR;
                r_chk       <= '0;
            end
            if (w_xfer) begin
                case (r_state)
                    c_ST_CNT_H: begin
                        r_chk    <= r_chk ^ byte_in;
                        r_cnt_hi <= byte_in;
                    end
                    c_ST_CNT_L: begin
                        r_chk    <= r_chk ^ byte_in;
                        r_remain <= w_count;
                        if (w_too_big) r_error <= 1'b1;
                    end
                    c_ST_DATA: begin
                        r_chk <= r_chk ^ byte_in;
                        if (w_byte_idx == 2'd3) r_remain <= r_remain - 16'd1;
                    end
                    c_ST_CHECK: begin
                        if (byte_in == r_chk) begin
                            r_cpu_reset <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    imem_program_loader_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start),
        .i_shift_en   (w_shift_en),
        .i_byte       (byte_in),
        .o_byte_idx   (w_byte_idx),
        .o_word_ready (w_word_ready),
        .o_word       (w_word)
    );

    assign byte_ready = r_byte_ready;
    assign imem_we    = w_word_ready;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_done;
    assign load_error = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_program_loader
// Brief  : Directed and randomized frame bench for imem_program_loader.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_imem_program_loader;

    localparam logic [31:0] c_BASE = 32'd0;
    localparam logic [31:0] c_STEP = 32'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    wire         byte_ready;
    wire         imem_we;
    wire  [31:0] imem_addr;
    wire  [31:0] imem_wdata;
    wire         cpu_reset;
    wire         load_done;
    wire         load_error;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  frame_q[$];
    logic        exp_done;

    imem_program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ctl"}, {59'd0, byte_ready, imem_we, cpu_reset, load_done, load_error}, 64'b00100);
        check({tag, " addr"}, {32'd0, imem_addr}, {32'd0, c_BASE});
        check({tag, " wdata"}, {32'd0, imem_wdata}, 64'd0);
    endtask

    // Reference: parse the frame as a whole and list the writes it must produce.
    task automatic model();
        int          i = 0;
        int          cnt;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] w;
        exp_q.delete();
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        cnt = int'(frame_q[i+1]) * 256 + int'(frame_q[i+2]);
        if (cnt > 256) begin
            exp_done = 1'b0;
            return;
        end
        x = frame_q[i+1] ^ frame_q[i+2];
        for (int k = 0; k < cnt; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                b = frame_q[i + 3 + 4*k + j];
                w = w + ({24'd0, b} << (8*j));
                x = x ^ b;
            end
            exp_q.push_back({c_BASE + c_STEP * 32'(k), w});
        end
        exp_done = (frame_q[i + 3 + 4*cnt] == x);
    endtask

    task automatic run_frame(input string tag, input int gap_mode);
        int last;
        model();
        last = frame_q.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (i == last) check({tag, " busy"}, {63'd0, cpu_reset}, 64'd1);
            byte_in    = frame_q[i];
            byte_valid = 1'b1;
            tick();
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            if (i == last) begin
                check({tag, " cpu_reset"}, {63'd0, cpu_reset}, {63'd0, ~exp_done});
                check({tag, " status"}, {62'd0, load_done, load_error}, {62'd0, exp_done, ~exp_done});
            end
            if (gap_mode == 1) tick();
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
        check({tag, " nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, " write"}, obs_q[i], exp_q[i]);
        check({tag, " addr"}, {32'd0, imem_addr}, {32'd0, c_BASE + c_STEP * 32'(exp_q.size())});
        check({tag, " held"}, {62'd0, load_done, load_error}, {62'd0, exp_done, ~exp_done});
        obs_q.delete();
    endtask

    task automatic set_frame1(input logic [7:0] chk);
        frame_q = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h8B,
                   8'h02, 8'h00, 8'h01, 8'hCB, chk};
    endtask

    task automatic random_frame(input int cnt, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back((b == 8'hA5) ? 8'h5A : b);
        end
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(cnt >> 8));
        frame_q.push_back(8'(cnt));
        if (cnt > 256) return;
        x = 8'(cnt >> 8) ^ 8'(cnt);
        for (int i = 0; i < 4*cnt; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();
        check("ready", {63'd0, byte_ready}, 64'd1);

        set_frame1(8'h42);
        run_frame("t1", 0);
        check("t1 word0", exp_q[0], {32'd0, 32'h8B020001});

        set_frame1(8'h43);
        run_frame("t2", 0);

        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("t3", 0);

        frame_q = {8'hA5, 8'h01, 8'h01};
        run_frame("t4a", 0);
        frame_q = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("t4b", 0);

        set_frame1(8'h42);
        frame_q.push_front(8'hFF);
        frame_q.push_front(8'h00);
        run_frame("t5", 1);

        frame_q = {8'hA5, 8'h00, 8'h02, 8'h01, 8'h00};
        foreach (frame_q[i]) begin
            byte_in    = frame_q[i];
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        reset      = 1'b0;
        tick();
        check_reset_state("t6 reset");
        tick();
        check("t6 nowrite", 64'(obs_q.size()), 64'd0);
        reset = 1'b1;
        tick();
        obs_q.delete();
        set_frame1(8'h42);
        run_frame("t6", 0);

        random_frame(256, 1'b0);
        run_frame("max", 0);

        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 5) == 0) random_frame($urandom_range(257, 65535), 1'b0);
            else random_frame($urandom_range(0, 6), $urandom_range(0, 2) == 0);
            run_frame("rand", 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
